inst_fetcher: RTL
=================

Name: inst_fetcher

Overview:
- Instruction fetch stage directly upstream of mem_ctrl's IF port.
- Owns the PC and a small direct-mapped instruction cache.
- Issues word fetches to mem_ctrl on a miss and streams {inst, pc} to the decoder at up to one instruction per cycle.
- Accepts redirects (jump/branch-mispredict PC) from downstream.

Parameters:
- RESET_PC, 32'h0, PC value loaded on reset.
- ICACHE_IDX_W, 4, index width; the cache holds 2^ICACHE_IDX_W one-word lines (16 by default).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset (rst==0 at a posedge resets the block).
- rdy  in  1  global ready; when 0, all state holds.
- inst_IF_req  out  1  fetch request to mem_ctrl.
- inst_IF_addr  out  32  byte address of the word being fetched.
- inst_IF_flag  in  1  one-cycle pulse from mem_ctrl; inst_IF is valid in the same cycle.
- inst_IF  in  32  fetched word, little-endian.
- dec_stall  in  1  decoder/issue cannot accept an instruction this cycle.
- jump_flag  in  1  redirect request.
- jump_pc  in  32  redirect target; bits [1:0] are ignored and treated as 0.
- inst_valid  out  1  registered; one-cycle valid for inst/inst_pc.
- inst  out  32  registered instruction word.
- inst_pc  out  32  registered PC of inst.

Behaviour:
- Reset (rst==0 at a posedge):
  - pc=RESET_PC; state=LOOKUP; all cache valid bits cleared; jump_pend=0.
  - inst_valid=0, inst=0, inst_pc=0.
  - inst_IF_req=0, inst_IF_addr=0.
  - Reset wins over rdy and every other input, including mid-miss; the in-flight memory word is discarded.
- rdy==0: no register changes. inst_IF_req/inst_IF_addr keep the values implied by the held state.
- Cache:
  - Line i = {valid, tag[31-ICACHE_IDX_W-2:0], data[31:0]}.
  - index = pc[ICACHE_IDX_W+1:2]; tag = pc[31:ICACHE_IDX_W+2].
  - Hit = valid[index] && tag match (combinational).
- State LOOKUP:
  - jump_flag=1: pc<=jump_pc. No emit (inst_valid<=0). Stay in LOOKUP. Jump has priority over hit/emit.
  - Hit and !dec_stall: inst_valid<=1, inst<=data, inst_pc<=pc, pc<=pc+4 (32-bit wrap, 32'hFFFFFFFC -> 0).
  - Hit and dec_stall: inst_valid<=0; pc held.
  - Miss: inst_valid<=0; state<=MISS.
- State MISS:
  - inst_IF_addr=pc (combinational).
  - inst_IF_req = !inst_IF_flag (combinational): high every MISS cycle except the cycle the flag arrives. This lets mem_ctrl complete exactly one 4-byte read.
  - inst_valid<=0 in every MISS cycle.
  - Flag cycle: write line[index] = {1, tag, inst_IF}; state<=LOOKUP.
    - If jump_pend or jump_flag, pc<=target (jump_flag this cycle beats the pending one); clear jump_pend.
    - Otherwise pc is unchanged and the next LOOKUP hits.
  - jump_flag without flag: jump_pend<=1 and pend_pc<=jump_pc; the latest jump wins. The memory transaction is never aborted; the fill still occurs.
- Latency:
  - Hit: 1 cycle from LOOKUP to inst_valid.
  - Miss on an idle mem_ctrl: MISS is entered 1 cycle after LOOKUP; req is high for 4 cycles; flag arrives in the 5th; LOOKUP (hit) follows; inst_valid asserts 1 cycle later.
- dec_stall does not affect a MISS in progress.

Optional Feature:
- ICACHE_EN defined: the cache is as described, with 2^ICACHE_IDX_W lines.
- ICACHE_EN undefined:
  - The cache collapses to a single-entry buffer with a full 30-bit tag (pc[31:2]) and one valid bit; ICACHE_IDX_W is ignored.
  - Sequential code misses on every new PC.
  - Handshake, state machine and redirect rules are unchanged.

Test Plan:
- Reset with RESET_PC=0, memory word 0 = 32'h00000013 -> req high 4 cycles with addr=0; after the flag, inst_valid=1, inst=32'h00000013, inst_pc=0.
- Straight-line loop over 0x0..0xC twice (ICACHE_EN) -> second pass emits 4 instructions on 4 consecutive cycles with no req.
- dec_stall=1 for 3 cycles during hits -> inst_valid=0 those cycles, pc held; then resumes at the same pc without skipping.
- jump_flag with jump_pc=0x40 during MISS at pc=0x8 -> fill of 0x8 completes, no emit of 0x8; next req addr=0x40, then inst_pc=0x40.
- jump_flag coincident with hit at pc=0x4, jump_pc=0x100 -> no emit at 0x4; next lookup at 0x100.
- rst driven to 0 in the 2nd req cycle of a miss -> next cycle req=0, inst_valid=0, all valid bits cleared; fetch restarts at RESET_PC. rdy=0 for 5 cycles mid-miss -> req/addr frozen, no state change.

Source files
------------

// File: rtl/inst_fetcher.sv
// Instruction fetch stage: owns the PC, a direct-mapped one-word-line I-cache, and the mem_ctrl IF handshake.
// Define ICACHE_EN for the 2^ICACHE_IDX_W-line cache; otherwise a single-entry buffer tagged with pc[31:2].
module inst_fetcher #(
    parameter logic [31:0] RESET_PC     = 32'h0,
    parameter int          ICACHE_IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        inst_IF_req,
    output logic [31:0] inst_IF_addr,
    input  logic        inst_IF_flag,
    input  logic [31:0] inst_IF,
    input  logic        dec_stall,
    input  logic        jump_flag,
    input  logic [31:0] jump_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    typedef enum logic {
        LOOKUP = 1'b0,
        MISS   = 1'b1
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic        jump_pend, jump_pend_n;
    logic [31:0] pend_pc, pend_pc_n;
    logic        inst_valid_n;
    logic [31:0] inst_n, inst_pc_n;
    logic        fill;
    logic [31:0] jump_tgt;
    logic        unused_jump_lo;

    assign jump_tgt       = {jump_pc[31:2], 2'b00};
    assign unused_jump_lo = ^jump_pc[1:0];

`ifdef ICACHE_EN
    localparam int IDX_W = ICACHE_IDX_W;
    localparam int LINES = 2 ** IDX_W;
    localparam int TAG_W = 30 - IDX_W;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    assign idx = pc[IDX_W+1:2];
    assign tag = pc[31:IDX_W+2];
`else
    // The single-entry buffer has no index, so the index width has no effect here.
    localparam int unused_idx_w = ICACHE_IDX_W;
    localparam int LINES = 1;
    localparam int TAG_W = 30;

    logic [0:0]       idx;
    logic [TAG_W-1:0] tag;
    assign idx = 1'b0;
    assign tag = pc[31:2];
`endif

    logic [LINES-1:0] line_vld;
    logic [TAG_W-1:0] line_tag  [LINES];
    logic [31:0]      line_data [LINES];
    logic             hit;

    assign hit = line_vld[idx] && (line_tag[idx] == tag);

    // Request drops in the flag cycle so mem_ctrl sees exactly one read per miss.
    assign inst_IF_req  = (state == MISS) && !inst_IF_flag;
    assign inst_IF_addr = (state == MISS) ? pc : 32'h0;

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        jump_pend_n  = jump_pend;
        pend_pc_n    = pend_pc;
        inst_valid_n = 1'b0;
        inst_n       = inst;
        inst_pc_n    = inst_pc;
        fill         = 1'b0;
        case (state)
            LOOKUP: begin
                if (jump_flag) begin
                    pc_n = jump_tgt;
                end else if (hit) begin
                    if (!dec_stall) begin
                        inst_valid_n = 1'b1;
                        inst_n       = line_data[idx];
                        inst_pc_n    = pc;
                        pc_n         = pc + 32'd4;
                    end
                end else begin
                    state_n = MISS;
                end
            end
            MISS: begin
                if (inst_IF_flag) begin
                    fill        = 1'b1;
                    state_n     = LOOKUP;
                    jump_pend_n = 1'b0;
                    if (jump_flag)
                        pc_n = jump_tgt;
                    else if (jump_pend)
                        pc_n = pend_pc;
                end else if (jump_flag) begin
                    // The read in flight is never aborted; the redirect waits for the fill.
                    jump_pend_n = 1'b1;
                    pend_pc_n   = jump_tgt;
                end
            end
            default: state_n = LOOKUP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= LOOKUP;
            pc         <= RESET_PC;
            jump_pend  <= 1'b0;
            pend_pc    <= 32'h0;
            inst_valid <= 1'b0;
            inst       <= 32'h0;
            inst_pc    <= 32'h0;
            line_vld   <= '0;
        end else if (rdy) begin
            state      <= state_n;
            pc         <= pc_n;
            jump_pend  <= jump_pend_n;
            pend_pc    <= pend_pc_n;
            inst_valid <= inst_valid_n;
            inst       <= inst_n;
            inst_pc    <= inst_pc_n;
            if (fill)
                line_vld[idx] <= 1'b1;
        end
    end

    // Tag/data storage needs no reset; the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (rst && rdy && fill) begin
            line_tag[idx]  <= tag;
            line_data[idx] <= inst_IF;
        end
    end

endmodule
